cpu_control_unit: RTL

- Hardwired multi-cycle control sequencer that drives every load (L*), bus-enable (T*), memory (rd/wr) and ALU-select (fsel) control input of the CPU datapath.
- Consumes the instruction register contents (IR1) and the ALU flags (C,V,S,Z) that the datapath returns.
- Runs fetch -> execute state sequences so that the datapath plus this block form a complete CPU.

---
 rtl/cpu_control_unit.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired multi-cycle control sequencer for the CPU datapath.
// Each instruction is fetched (F0, F1, F2) and then executed in up to four
// states (EX0..EX3). A 3-bit wait counter stretches every memory read to
// MEM_LAT cycles.
// Optional build macro CU_COND_EXT_EN: when defined, opcode B is JS (jump if
// S) and opcode C is JV (jump if V). When undefined, both execute as NOP.
module cpu_control_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR1,
    input  logic        C,
    input  logic        V,
    input  logic        S,
    input  logic        Z,
    output logic        Lmar,
    output logic        Lir,
    output logic        Lbuff,
    output logic        Lpc,
    output logic        Lsp,
    output logic        Lreg,
    output logic        Lmdr,
    output logic        Lalu,
    output logic        Tpc,
    output logic        Tmdr,
    output logic        T1,
    output logic        Tbuff,
    output logic        Tsp,
    output logic        Treg,
    output logic        Tlabel,
    output logic        rd,
    output logic        wr,
    output logic [2:0]  fsel,
    output logic        halted,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        S_F0, S_F1, S_F2, S_EX0, S_EX1, S_EX2, S_EX3, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
        OP_LD   = 4'h4, OP_ST   = 4'h5, OP_JMP  = 4'h6, OP_JZ   = 4'h7,
        OP_JC   = 4'h8, OP_PUSH = 4'h9, OP_POP  = 4'hA, OP_JS   = 4'hB,
        OP_JV   = 4'hC, OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        FS_PASS = 3'b000, FS_ADD = 3'b001, FS_SUB = 3'b010, FS_AND = 3'b011,
        FS_OR   = 3'b100, FS_XOR = 3'b101, FS_NOT = 3'b110, FS_BMA = 3'b111
    } fsel_e;

    // All control outputs are gathered in one struct so that the reset gate is a single assignment.
    typedef struct packed {
        logic  lmar, lir, lbuff, lpc, lsp, lreg, lmdr, lalu;
        logic  tpc, tmdr, t1, tbuff, tsp, treg, tlabel;
        logic  rd, wr;
        fsel_e fsel;
        logic  halted, done;
    } ctrl_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t      ctrl, ctrl_g;
    op_e        op;
    logic       last_rd;

    assign op      = op_e'(IR1[15:12]);
    assign last_rd = (cnt_q == 3'd0);

`ifdef CU_COND_EXT_EN
    logic unused_ir;
    assign unused_ir = ^IR1[11:0];
`else
    logic unused_ir;
    assign unused_ir = ^{IR1[11:0], S, V};
`endif

    // State and wait-counter registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!rst) begin
            state_q <= S_F0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, wait-counter update and control decode for the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        ctrl    = '0;
        state_d = state_q;
        cnt_d   = last_rd ? 3'd0 : cnt_q - 3'd1;
        unique case (state_q)
            S_F0: begin
                ctrl.tpc = 1'b1; ctrl.lmar = 1'b1; ctrl.lbuff = 1'b1;
                state_d  = S_F1;
                cnt_d    = LAT_M1;
            end
            S_F1: begin
                ctrl.rd = 1'b1;
                if (cnt_q == LAT_M1) begin
                    ctrl.t1 = 1'b1; ctrl.tbuff = 1'b1; ctrl.fsel = FS_ADD; ctrl.lpc = 1'b1;
                end
                if (last_rd) begin
                    ctrl.lmdr = 1'b1;
                    state_d   = S_F2;
                end
            end
            S_F2: begin
                ctrl.tmdr = 1'b1; ctrl.lir = 1'b1;
                state_d   = S_EX0;
            end
            S_EX0: begin
                state_d = S_F0;
                case (op)
                    OP_LDI: begin
                        ctrl.tlabel = 1'b1; ctrl.lreg = 1'b1; ctrl.done = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        ctrl.treg = 1'b1; ctrl.lbuff = 1'b1;
                        state_d   = S_EX1;
                    end
                    OP_LD: begin
                        ctrl.tlabel = 1'b1; ctrl.lmar = 1'b1;
                        state_d     = S_EX1;
                        cnt_d       = LAT_M1;
                    end
                    OP_ST: begin
                        ctrl.tlabel = 1'b1; ctrl.lmar = 1'b1;
                        state_d     = S_EX1;
                    end
                    OP_JMP: begin
                        ctrl.tlabel = 1'b1; ctrl.lpc = 1'b1; ctrl.done = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl.tlabel = Z; ctrl.lpc = Z; ctrl.done = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.tlabel = C; ctrl.lpc = C; ctrl.done = 1'b1;
                    end
`ifdef CU_COND_EXT_EN
                    OP_JS: begin
                        ctrl.tlabel = S; ctrl.lpc = S; ctrl.done = 1'b1;
                    end
                    OP_JV: begin
                        ctrl.tlabel = V; ctrl.lpc = V; ctrl.done = 1'b1;
                    end
`endif
                    OP_PUSH: begin
                        ctrl.tsp = 1'b1; ctrl.lbuff = 1'b1;
                        state_d  = S_EX1;
                    end
                    OP_POP: begin
                        ctrl.tsp = 1'b1; ctrl.lmar = 1'b1; ctrl.lbuff = 1'b1;
                        state_d  = S_EX1;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: ctrl.done = 1'b1;
                endcase
            end
            S_EX1: begin
                state_d = S_F0;
                case (op)
                    OP_ADDI, OP_SUBI: begin
                        ctrl.tlabel = 1'b1; ctrl.tbuff = 1'b1; ctrl.lalu = 1'b1;
                        ctrl.lreg   = 1'b1; ctrl.done  = 1'b1;
                        ctrl.fsel   = (op == OP_ADDI) ? FS_ADD : FS_BMA;
                    end
                    OP_LD: begin
                        ctrl.rd = 1'b1;
                        state_d = S_EX1;
                        if (last_rd) begin
                            ctrl.lmdr = 1'b1;
                            state_d   = S_EX2;
                        end
                    end
                    OP_ST: begin
                        ctrl.treg = 1'b1; ctrl.lmdr = 1'b1;
                        state_d   = S_EX2;
                    end
                    OP_PUSH: begin
                        ctrl.t1  = 1'b1; ctrl.tbuff = 1'b1; ctrl.fsel = FS_BMA;
                        ctrl.lsp = 1'b1; ctrl.lmar  = 1'b1;
                        state_d  = S_EX2;
                    end
                    OP_POP: begin
                        ctrl.t1  = 1'b1; ctrl.tbuff = 1'b1; ctrl.fsel = FS_ADD;
                        ctrl.lsp = 1'b1;
                        state_d  = S_EX2;
                        cnt_d    = LAT_M1;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                state_d = S_F0;
                case (op)
                    OP_LD: begin
                        ctrl.tmdr = 1'b1; ctrl.lreg = 1'b1; ctrl.done = 1'b1;
                    end
                    OP_ST: begin
                        ctrl.wr = 1'b1; ctrl.done = 1'b1;
                    end
                    OP_PUSH: begin
                        ctrl.treg = 1'b1; ctrl.lmdr = 1'b1;
                        state_d   = S_EX3;
                    end
                    OP_POP: begin
                        ctrl.rd = 1'b1;
                        state_d = S_EX2;
                        if (last_rd) begin
                            ctrl.lmdr = 1'b1;
                            state_d   = S_EX3;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX3: begin
                state_d = S_F0;
                if (op == OP_PUSH) begin
                    ctrl.wr = 1'b1; ctrl.done = 1'b1;
                end else if (op == OP_POP) begin
                    ctrl.tmdr = 1'b1; ctrl.lreg = 1'b1; ctrl.done = 1'b1;
                end
            end
            S_HALT: ctrl.halted = 1'b1;
            default: state_d = S_F0;
        endcase
    end

    // While reset is held every control line is forced low.
    assign ctrl_g = rst ? ctrl : '0;

    assign Lmar       = ctrl_g.lmar;
    assign Lir        = ctrl_g.lir;
    assign Lbuff      = ctrl_g.lbuff;
    assign Lpc        = ctrl_g.lpc;
    assign Lsp        = ctrl_g.lsp;
    assign Lreg       = ctrl_g.lreg;
    assign Lmdr       = ctrl_g.lmdr;
    assign Lalu       = ctrl_g.lalu;
    assign Tpc        = ctrl_g.tpc;
    assign Tmdr       = ctrl_g.tmdr;
    assign T1         = ctrl_g.t1;
    assign Tbuff      = ctrl_g.tbuff;
    assign Tsp        = ctrl_g.tsp;
    assign Treg       = ctrl_g.treg;
    assign Tlabel     = ctrl_g.tlabel;
    assign rd         = ctrl_g.rd;
    assign wr         = ctrl_g.wr;
    assign fsel       = ctrl_g.fsel;
    assign halted     = ctrl_g.halted;
    assign instr_done = ctrl_g.done;

endmodule
